fetch_queue: RTL and testbench

- Fetch stage directly upstream of decode in the dual-issue Thumb-16 core.
- Holds the fetch PC and drives the halfword address to the combinational program ROM.
- Each cycle the ROM returns the halfwords at rom_addr and rom_addr+1; the block buffers them in a small circular queue.
- Presents up to two in-order instructions per cycle to decode; handles branch redirect (flush and reload).

---
 rtl/core_pkg.sv | 12 +
 rtl/hw_fifo_2w2r.sv | 54 +++++
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the Thumb-16 fetch path: address width default,
// halfword type, the empty-slot instruction value and the reset PC.
package core_pkg;

  localparam int          ADDR_W_DEF   = 14;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef logic [15:0] hw_t;

  localparam hw_t NOP_HW = 16'h0000;

endpackage : core_pkg

// File: rtl/hw_fifo_2w2r.sv
// Circular halfword buffer: writes exactly two entries per push, reads
// 0/1/2 entries per cycle, exposes the two oldest entries and the
// occupancy, and can be flushed to empty in one cycle.
module hw_fifo_2w2r
  import core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  hw_t              wdata0,
  input  hw_t              wdata1,
  input  logic [1:0]       take,
  output hw_t              rdata0,
  output hw_t              rdata1,
  output logic [CNT_W-1:0] count
);

  hw_t              mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // The caller guarantees push only with two free slots and take <= count.
  assign rdata0 = mem[rd_ptr];
  assign rdata1 = mem[rd_ptr + PTR_W'(1)];

  // Storage: a push writes the pair at wr_ptr and wr_ptr+1 (wrapping).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]               <= wdata0;
      mem[wr_ptr + PTR_W'(1)]   <= wdata1;
    end
  end

  // Pointer and occupancy update; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(take);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(2);
      end
      count <= count + (push ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(take);
    end
  end

endmodule : hw_fifo_2w2r

// File: rtl/fetch_queue.sv
// Fetch stage feeding a dual-issue decoder. Owns the fetch PC (drives the
// combinational program ROM), the PC of the oldest queued instruction,
// push/take arbitration and branch redirect.
//
// Decode handshake: ir0_valid/ir1_valid advertise how many instructions
// are presented; decode reports in the same cycle how many it consumes via
// dec_take (0..2, never more than are valid). Consumption takes effect at
// the next rising edge. A redirect cancels any consumption that cycle.
module fetch_queue
  import core_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_hw0,
  input  logic [15:0]       rom_hw1,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic [1:0]        dec_take,
  output logic [15:0]       ir0,
  output logic [15:0]       ir1,
  output logic              ir0_valid,
  output logic              ir1_valid,
  output logic [ADDR_W-1:0] issue_pc
);

  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC0   = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic [1:0]        take_req;
  logic [1:0]        take;
  hw_t               rdata0;
  hw_t               rdata1;

  // Push only whole pairs, and only when two slots are free before this
  // cycle's take is applied (no same-cycle bypass of freed slots).
  assign push = fetch_en & ~redirect_valid & (count <= CNT_W'(DEPTH - 2));

  // Effective take: clamp illegal requests to what is actually queued.
  always_comb begin
    take_req = (dec_take == 2'd3) ? 2'd2 : dec_take;
    take     = 2'd0;
    if (!redirect_valid) begin
      take = (CNT_W'(take_req) > count) ? count[1:0] : take_req;
    end
  end

  hw_fifo_2w2r #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_valid),
    .push   (push),
    .wdata0 (rom_hw0),
    .wdata1 (rom_hw1),
    .take   (take),
    .rdata0 (rdata0),
    .rdata1 (rdata1),
    .count  (count)
  );

  // Fetch PC and head PC: redirect reloads both, otherwise they advance
  // by the pushed pair and the consumed instructions respectively.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= PC0;
      head_pc  <= PC0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_addr;
      head_pc  <= redirect_addr;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(2);
      end
      head_pc <= head_pc + ADDR_W'(take);
    end
  end

  assign rom_addr  = fetch_pc;
  assign ir0_valid = (count >= CNT_W'(1));
  assign ir1_valid = (count >= CNT_W'(2));
  assign ir0       = ir0_valid ? rdata0 : NOP_HW;
  assign ir1       = ir1_valid ? rdata1 : NOP_HW;
  assign issue_pc  = head_pc;

  // Decode must not consume more than is presented.
  take_legal_a : assert property (@(posedge clk) disable iff (rst || redirect_valid)
    (dec_take != 2'd3) && (CNT_W'(dec_take) <= count));

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by randomized traffic,
// all checked against a queue-of-addresses reference model.
module tb_fetch_queue;

  localparam int AW    = 14;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          fetch_en;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_hw0;
  logic [15:0]   rom_hw1;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [1:0]    dec_take;
  logic [15:0]   ir0;
  logic [15:0]   ir1;
  logic          ir0_valid;
  logic          ir1_valid;
  logic [AW-1:0] issue_pc;

  logic [15:0]   rom_mem [0:(1<<AW)-1];

  // reference model state
  logic [15:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] m_fetch;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_hw0        (rom_hw0),
    .rom_hw1        (rom_hw1),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .dec_take       (dec_take),
    .ir0            (ir0),
    .ir1            (ir1),
    .ir0_valid      (ir0_valid),
    .ir1_valid      (ir1_valid),
    .issue_pc       (issue_pc)
  );

  // combinational program ROM
  assign rom_hw0 = rom_mem[rom_addr];
  assign rom_hw1 = rom_mem[rom_addr + AW'(1)];

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a list of pending instruction addresses. Reset or
  // redirect empties it; otherwise consume from the front, then append the
  // next two sequential addresses if two slots were free at cycle start.
  task automatic model_edge(input logic r, input logic fe, input logic rv,
                            input logic [AW-1:0] ra, input logic [1:0] tk);
    int  n;
    bit  do_push;
    if (r) begin
      exp_q.delete(); addr_q.delete(); m_fetch = '0;
    end else if (rv) begin
      exp_q.delete(); addr_q.delete(); m_fetch = ra;
    end else begin
      n       = exp_q.size();
      do_push = fe && (DEPTH - n >= 2);
      for (int i = 0; i < int'(tk); i++) begin
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(addr_q.pop_front());
        end
      end
      if (do_push) begin
        addr_q.push_back(m_fetch);
        addr_q.push_back(m_fetch + AW'(1));
        exp_q.push_back(rom_mem[m_fetch]);
        exp_q.push_back(rom_mem[m_fetch + AW'(1)]);
        m_fetch = m_fetch + AW'(2);
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    chk("rom_addr",  16'(rom_addr),  16'(m_fetch));
    chk("ir0_valid", 16'(ir0_valid), 16'(n >= 1));
    chk("ir1_valid", 16'(ir1_valid), 16'(n >= 2));
    chk("ir0",       ir0,            (n >= 1) ? exp_q[0] : 16'h0);
    chk("ir1",       ir1,            (n >= 2) ? exp_q[1] : 16'h0);
    chk("issue_pc",  16'(issue_pc),  16'((n >= 1) ? addr_q[0] : m_fetch));
  endtask

  // driver: apply inputs, clock once, update model, check 1 time unit later
  task automatic step(input logic r, input logic fe, input logic rv,
                      input logic [AW-1:0] ra, input logic [1:0] tk);
    rst            = r;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_addr  = ra;
    dec_take       = tk;
    @(posedge clk);
    model_edge(r, fe, rv, ra, tk);
    #1;
    check_all();
  endtask

  initial begin
    int lim;
    logic r, fe, rv;
    logic [AW-1:0] ra;
    logic [1:0] tk;

    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 16'($urandom);
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_addr = '0; dec_take = 2'd0;
    m_fetch = '0;
    #2;

    // reset
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("reset_issue_pc", 16'(issue_pc), 16'h0);

    // fill with no consumption
    step(0, 1, 0, 0, 0);
    chk("fill_ir0", ir0, rom_mem[0]);
    chk("fill_ir1", ir1, rom_mem[1]);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("full_rom_addr", 16'(rom_addr), 16'h4);

    // steady dual issue
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 2);

    // single issue
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1);
    if (exp_q.size() != 3) step(0, 1, 0, 0, 1);

    // redirect to the top of the address space with three queued
    step(0, 1, 1, 14'h3FFF, 2);
    chk("redir_rom_addr", 16'(rom_addr), 16'h3FFF);
    chk("redir_valid", 16'(ir0_valid), 16'h0);
    step(0, 1, 0, 0, 0);
    chk("wrap_ir0", ir0, rom_mem[14'h3FFF]);
    chk("wrap_ir1", ir1, rom_mem[0]);
    chk("wrap_issue_pc", 16'(issue_pc), 16'h3FFF);
    step(0, 1, 0, 0, 2);

    // reset wins over redirect and take
    step(1, 1, 1, 14'h0123, 2);
    chk("rst_wins_addr", 16'(rom_addr), 16'h0);
    chk("rst_wins_valid", 16'(ir0_valid), 16'h0);

    // drain with fetch held
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("drain1_ir1_valid", 16'(ir1_valid), 16'h0);
    chk("drain1_ir0_valid", 16'(ir0_valid), 16'h1);
    step(0, 0, 0, 0, 1);
    chk("drain2_ir0_valid", 16'(ir0_valid), 16'h0);
    chk("drain2_rom_addr", 16'(rom_addr), 16'h2);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      fe  = ($urandom_range(0, 3) != 0);
      ra  = AW'($urandom);
      lim = exp_q.size() < 2 ? exp_q.size() : 2;
      tk  = (r || rv) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, lim));
      step(r, fe, rv, ra, tk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_queue
